// File: rtl/pri_enc_pkg.sv
// Shared definitions for the scanning priority encoder.
//   - FSM state type and state constants (IDLE, SCAN, DONE)
//   - clog2(): encoded index width for an N-input encoder (minimum 1)
package pri_enc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Smallest w with 2**w >= value, never less than 1 so a 2-input
  // encoder still has a 1-bit index.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pri_find_msb.sv
// Combinational most-significant-set-bit finder.
//   vec  in  N  active-high request vector
//   idx  out W  index of the highest set bit (0 when none set)
//   any  out 1  1 when at least one bit of vec is set
module pri_find_msb
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // NOTE: every combinational output gets a default before the loop;
  // otherwise paths that assign nothing would infer latches.
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Ascending scan: the last hit, i.e. the highest index, wins.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_encoder_scan.sv
// N-input active-low priority encoder with registered outputs and a
// scan mode that snapshots all active requests and hands them out one
// per valid/ready handshake, highest index first.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   EI_n   in  1  enable, active-low (high in SCAN/DONE aborts the sweep)
//   I_n    in  N  requests, active-low, bit N-1 highest priority
//   scan   in  1  start a sweep (sampled in IDLE only)
//   ready  in  1  consumer accepts the current index (SCAN only)
//   A_n    out W  inverted encoded index
//   GS_n   out 1  0 = A_n holds a valid index
//   EO_n   out 1  0 = enabled with no request, or sweep-complete pulse
//   valid  out 1  inverse of GS_n
//   busy   out 1  1 while in SCAN or DONE
module pri_encoder_scan
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         EI_n,
  input  logic [N-1:0] I_n,
  input  logic         scan,
  input  logic         ready,
  output logic [W-1:0] A_n,
  output logic         GS_n,
  output logic         EO_n,
  output logic         valid,
  output logic         busy
);

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   a_n_q, a_n_d;
  logic           gs_n_q, gs_n_d;
  logic           eo_n_q, eo_n_d;
  logic           busy_q, busy_d;

  logic [W-1:0]   cur_idx;
  logic [N-1:0]   pend_rest;
  logic [N-1:0]   find_vec;
  logic [W-1:0]   find_idx;
  logic           find_any;

  logic [W-1:0]   enc_a_n;
  logic           enc_gs_n;
  logic           enc_eo_n;

  // In SCAN the index on A_n is msb(pend); pend_rest is the snapshot with
  // that item removed, so the finder already looks one item ahead and the
  // registered outputs can advance every cycle while ready stays high.
  assign cur_idx = ~a_n_q;

  always_comb begin
    pend_rest = '0;
    for (int i = 0; i < N; i++) begin
      pend_rest[i] = pend_q[i] & (W'(i) != cur_idx);
    end
  end

  // Outside SCAN the finder encodes the live inputs (IDLE, and the
  // DONE -> IDLE transition that reloads the direct encode).
  assign find_vec = (state_q == ST_SCAN) ? pend_rest : ~I_n;

  pri_find_msb #(.N(N)) u_find (
    .vec (find_vec),
    .idx (find_idx),
    .any (find_any)
  );

  // Direct encode of the live inputs; only meaningful outside SCAN.
  always_comb begin
    enc_a_n  = '1;
    enc_gs_n = 1'b1;
    enc_eo_n = 1'b1;
    if (!EI_n) begin
      if (find_any) begin
        enc_a_n  = ~find_idx;
        enc_gs_n = 1'b0;
      end else begin
        enc_eo_n = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    a_n_d   = a_n_q;
    gs_n_d  = gs_n_q;
    eo_n_d  = eo_n_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        a_n_d  = enc_a_n;
        gs_n_d = enc_gs_n;
        eo_n_d = enc_eo_n;
        busy_d = 1'b0;
        // The encode loaded this cycle is already the first scan item.
        if (scan && !EI_n && find_any) begin
          pend_d  = ~I_n;
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end
      end

      ST_SCAN: begin
        // Abort takes priority over a handshake on the same edge.
        if (EI_n) begin
          pend_d  = '0;
          state_d = ST_IDLE;
          a_n_d   = '1;
          gs_n_d  = 1'b1;
          eo_n_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (!gs_n_q && ready) begin
          pend_d = pend_rest;
          if (find_any) begin
            a_n_d = ~find_idx;
          end else begin
            state_d = ST_DONE;
            a_n_d   = '1;
            gs_n_d  = 1'b1;
            eo_n_d  = 1'b0;
          end
        end
      end

      ST_DONE: begin
        pend_d  = '0;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (EI_n) begin
          a_n_d  = '1;
          gs_n_d = 1'b1;
          eo_n_d = 1'b1;
        end else begin
          a_n_d  = enc_a_n;
          gs_n_d = enc_gs_n;
          eo_n_d = enc_eo_n;
        end
      end

      default: begin
        pend_d  = '0;
        state_d = ST_IDLE;
        a_n_d   = '1;
        gs_n_d  = 1'b1;
        eo_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      a_n_q   <= '1;
      gs_n_q  <= 1'b1;
      eo_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_n_q   <= a_n_d;
      gs_n_q  <= gs_n_d;
      eo_n_q  <= eo_n_d;
      busy_q  <= busy_d;
    end
  end

  assign A_n   = a_n_q;
  assign GS_n  = gs_n_q;
  assign EO_n  = eo_n_q;
  assign valid = ~gs_n_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pri_encoder_scan.sv
// Directed bench for pri_encoder_scan: an 8-input and a 12-input instance
// share control inputs; each step drives inputs just after a rising edge
// and checks the registered outputs 1 ns after the following edge.
module tb_pri_encoder_scan;

  logic        clk;
  logic        rst_n;
  logic        EI_n;
  logic        scan;
  logic        ready;

  logic [7:0]  I8_n;
  logic [2:0]  A8_n;
  logic        GS8_n, EO8_n, valid8, busy8;

  logic [11:0] I12_n;
  logic [3:0]  A12_n;
  logic        GS12_n, EO12_n, valid12, busy12;

  int vectors;
  int miscompares;

  pri_encoder_scan #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .EI_n  (EI_n),
    .I_n   (I8_n),
    .scan  (scan),
    .ready (ready),
    .A_n   (A8_n),
    .GS_n  (GS8_n),
    .EO_n  (EO8_n),
    .valid (valid8),
    .busy  (busy8)
  );

  pri_encoder_scan #(.N(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .EI_n  (EI_n),
    .I_n   (I12_n),
    .scan  (scan),
    .ready (ready),
    .A_n   (A12_n),
    .GS_n  (GS12_n),
    .EO_n  (EO12_n),
    .valid (valid12),
    .busy  (busy12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed {A_n, GS_n, EO_n, valid, busy} for each instance.
  function automatic logic [15:0] obs8();
    return {9'b0, A8_n, GS8_n, EO8_n, valid8, busy8};
  endfunction

  function automatic logic [15:0] obs12();
    return {8'b0, A12_n, GS12_n, EO12_n, valid12, busy12};
  endfunction

  function automatic logic [15:0] e8(input logic [2:0] a, input logic gs,
                                     input logic eo, input logic v, input logic b);
    return {9'b0, a, gs, eo, v, b};
  endfunction

  function automatic logic [15:0] e12(input logic [3:0] a, input logic gs,
                                      input logic eo, input logic v, input logic b);
    return {8'b0, a, gs, eo, v, b};
  endfunction

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    EI_n  = 1'b1;
    scan  = 1'b0;
    ready = 1'b0;
    I8_n  = 8'hFF;
    I12_n = 12'hFFF;

    // Reset state
    #12;
    check("reset8",  obs8(),  e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));
    check("reset12", obs12(), e12(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Direct encode: highest zero is bit 6
    EI_n = 1'b0;
    I8_n = 8'b1011_0111;
    tick();
    check("direct_b6", obs8(), e8(3'b001, 1'b0, 1'b1, 1'b1, 1'b0));
    I8_n = 8'hFF;
    tick();
    check("direct_none", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b0));

    // Disabled: scan requested with all inputs active, must stay idle
    EI_n = 1'b1;
    I8_n = 8'h00;
    scan = 1'b1;
    tick();
    check("disabled_1", obs8(), e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("disabled_2", obs8(), e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));

    // Scan with ready held high: items 7, 2, 0 then DONE then IDLE
    EI_n  = 1'b0;
    scan  = 1'b1;
    ready = 1'b1;
    I8_n  = 8'b0111_1010;
    tick();
    check("scan_item7", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    scan = 1'b0;
    tick();
    check("scan_item2", obs8(), e8(3'b101, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("scan_item0", obs8(), e8(3'b111, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("scan_done", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    check("scan_idle", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    I8_n = 8'hFF;
    tick();
    check("scan_idle_none", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b0));

    // Backpressure: ready low 3 cycles, inputs change under the snapshot
    scan  = 1'b1;
    ready = 1'b0;
    I8_n  = 8'b0111_1010;
    tick();
    check("bp_first", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    scan = 1'b0;
    I8_n = 8'hFE;
    tick();
    check("bp_hold1", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("bp_hold2", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("bp_hold3", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    ready = 1'b1;
    tick();
    check("bp_item2", obs8(), e8(3'b101, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("bp_item0", obs8(), e8(3'b111, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("bp_done", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    check("bp_idle_fe", obs8(), e8(3'b111, 1'b0, 1'b1, 1'b1, 1'b0));

    // Abort after the first accept, with ready still high
    scan = 1'b1;
    I8_n = 8'b0111_1010;
    tick();
    check("abort_item7", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    scan = 1'b0;
    tick();
    check("abort_item2", obs8(), e8(3'b101, 1'b0, 1'b1, 1'b1, 1'b1));
    EI_n = 1'b1;
    tick();
    check("abort_off", obs8(), e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("abort_no_done", obs8(), e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset in the middle of a sweep
    EI_n  = 1'b0;
    scan  = 1'b1;
    ready = 1'b0;
    I8_n  = 8'b0111_1010;
    tick();
    check("rst_pre", obs8(), e8(3'b000, 1'b0, 1'b1, 1'b1, 1'b1));
    scan = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_scan", obs8(), e8(3'b111, 1'b1, 1'b1, 1'b0, 1'b0));
    I8_n = 8'hFF;
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_after", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b0));

    // 12-input instance: index 11 encodes to 4'b0100
    I12_n = 12'b0111_1111_1111;
    tick();
    check("n12_direct", obs12(), e12(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0));
    scan  = 1'b1;
    ready = 1'b1;
    I12_n = 12'b0111_1111_0111;
    tick();
    check("n12_item11", obs12(), e12(4'b0100, 1'b0, 1'b1, 1'b1, 1'b1));
    scan = 1'b0;
    tick();
    check("n12_item3", obs12(), e12(4'b1100, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("n12_done", obs12(), e12(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1));
    check("n8_idle_during_n12", obs8(), e8(3'b111, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
